// File: rtl/johnson_phase_sequencer.sv
// -----------------------------------------------------------------------------
// johnson_phase_sequencer
//
// Owns an N-stage Johnson (twisted-ring) counter and schedules its rotation.
// A run is started from IDLE, can be frozen with hold, aborted with stop, and
// ends by itself after run_len full 2N-phase rotations (run_len = 0 runs until
// stopped). The ring state is decoded into a one-hot phase strobe for
// downstream phase-sliced datapaths.
//
// Parameters
//   N      Johnson stages (sequence length 2*N), N >= 2
//   CNT_W  width of run_len and rot_cnt
//
// Ports
//   Clk      in   rising-edge clock
//   rst      in   synchronous, active-high reset (overrides everything)
//   start    in   begin a run; only looked at in IDLE
//   stop     in   abort the run; highest priority command
//   hold     in   freeze the ring while asserted (RUN <-> PAUSE)
//   run_len  in   rotations per run, latched on start; 0 = continuous
//   q        out  Johnson ring state
//   phase    out  one-hot phase decode of q (combinational)
//   busy     out  high whenever the sequencer is not IDLE
//   done     out  one-cycle pulse when the programmed rotations complete
//   rot_cnt  out  rotations completed in the current or most recent run
// -----------------------------------------------------------------------------
module johnson_phase_sequencer #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic [CNT_W-1:0] run_len,
  output logic [N-1:0]     q,
  output logic [2*N-1:0]   phase,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] rot_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Last ring state of a rotation: a single 1 in the MSB.
  localparam logic [N-1:0] LAST_Q = {1'b1, {(N-1){1'b0}}};

  state_t           state;
  logic [CNT_W-1:0] run_len_q;
  logic [CNT_W-1:0] rot_nxt;
  logic             rot_done;

  assign rot_nxt  = rot_cnt + CNT_W'(1);
  // Rotation completes on the advance out of the last ring state.
  assign rot_done = (q == LAST_Q);

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge Clk) begin
    if (rst) begin
      state     <= IDLE;
      q         <= '0;
      rot_cnt   <= '0;
      run_len_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            state     <= RUN;
            busy      <= 1'b1;
            q         <= '0;
            rot_cnt   <= '0;
            run_len_q <= run_len;
          end
        end

        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            q     <= '0;
          end else if (hold) begin
            state <= PAUSE;
          end else begin
            q <= {q[N-2:0], ~q[N-1]};
            if (rot_done) begin
              rot_cnt <= rot_nxt;
              // The advance out of LAST_Q already lands q on 0.
              if ((run_len_q != '0) && (rot_nxt == run_len_q)) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end

        PAUSE: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            q     <= '0;
          end else if (!hold) begin
            // Resume edge only re-enters RUN; the ring advances next edge.
            state <= RUN;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          q     <= '0;
        end
      endcase
    end
  end

  // Phase index: popcount(q) on the filling half of the sequence,
  // 2N - popcount(q) on the draining half.
  int ones;
  int idx;

  // NOTE: every combinational output gets a default before any conditional
  // assignment so no latch is inferred.
  always_comb begin
    ones  = 0;
    phase = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + int'(q[i]);
    end
    idx = q[N-1] ? (2 * N - ones) : ones;
    for (int j = 0; j < 2 * N; j++) begin
      phase[j] = (j == idx);
    end
  end

endmodule

// File: tb/tb_johnson_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_johnson_phase_sequencer
//
// Scoreboard bench. The driver applies one cycle of stimulus, advances an
// abstract reference model (run mode, phase index 0..2N-1, rotation count)
// and pushes the expected post-edge outputs into a queue. A monitor on the
// falling edge pops one entry per cycle and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_johnson_phase_sequencer;

  localparam int N     = 4;
  localparam int CNT_W = 2;

  logic             Clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             hold = 1'b0;
  logic [CNT_W-1:0] run_len = '0;
  logic [N-1:0]     q;
  logic [2*N-1:0]   phase;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] rot_cnt;

  johnson_phase_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .Clk     (Clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .hold    (hold),
    .run_len (run_len),
    .q       (q),
    .phase   (phase),
    .busy    (busy),
    .done    (done),
    .rot_cnt (rot_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [N-1:0]     q;
    logic [2*N-1:0]   phase;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] rot_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 running, 2 paused. k is the position in the 2N sequence.
  int m_mode = 0;
  int m_k    = 0;
  int m_rot  = 0;
  int m_len  = 0;
  int m_done = 0;

  // Ring contents for sequence position k: k ones filling from the LSB, then
  // ones draining out of the LSB end.
  function automatic logic [N-1:0] ring_of(input int k);
    int v;
    if (k <= N) v = (1 << k) - 1;
    else        v = ((1 << N) - 1) << (k - N);
    return N'(v);
  endfunction

  task automatic model_edge(input logic r, input logic st, input logic sp,
                            input logic h, input int len);
    m_done = 0;
    if (r) begin
      m_mode = 0; m_k = 0; m_rot = 0;
    end else begin
      case (m_mode)
        0: if (st && !sp) begin m_mode = 1; m_k = 0; m_rot = 0; m_len = len; end
        1: begin
          if (sp) begin m_mode = 0; m_k = 0; end
          else if (h) m_mode = 2;
          else if (m_k == 2 * N - 1) begin
            m_k   = 0;
            m_rot = (m_rot + 1) % (1 << CNT_W);
            if (m_len != 0 && m_rot == m_len) begin m_mode = 0; m_done = 1; end
          end else m_k = m_k + 1;
        end
        default: begin
          if (sp) begin m_mode = 0; m_k = 0; end
          else if (!h) m_mode = 1;
        end
      endcase
    end
  endtask

  // One clock of stimulus; the expectation is queued once the edge has passed.
  task automatic step(input logic r, input logic st, input logic sp,
                      input logic h, input int len);
    exp_t e;
    rst = r; start = st; stop = sp; hold = h; run_len = CNT_W'(len);
    model_edge(r, st, sp, h, len);
    e.q       = ring_of(m_k);
    e.phase   = (2*N)'(1) << m_k;
    e.busy    = (m_mode != 0);
    e.done    = (m_done != 0);
    e.rot_cnt = CNT_W'(m_rot);
    @(posedge Clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("q",       32'(q),       32'(e.q));
      check("phase",   32'(phase),   32'(e.phase));
      check("busy",    32'(busy),    32'(e.busy));
      check("done",    32'(done),    32'(e.done));
      check("rot_cnt", 32'(rot_cnt), 32'(e.rot_cnt));
      if (done) done_seen++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset state.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    idle_cycles(2);

    // Single rotation: q walks the full sequence, then done with rot_cnt=1.
    step(0, 1, 0, 0, 1);
    idle_cycles(10);

    // Three rotations with start pulses while busy that must be ignored.
    step(0, 1, 0, 0, 3);
    for (int i = 0; i < 26; i++) step(0, (i % 5) == 2, 0, 0, 1);

    // Hold for 5 cycles at q=0011, then resume and finish.
    step(0, 1, 0, 0, 1);
    idle_cycles(2);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    idle_cycles(12);

    // stop with hold and start high at q=1110: aborts, no done.
    step(0, 1, 0, 0, 0);
    idle_cycles(5);
    step(0, 1, 1, 1, 2);
    idle_cycles(3);

    // Mid-run reset.
    step(0, 1, 0, 0, 2);
    idle_cycles(3);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    idle_cycles(2);

    // Continuous run: rot_cnt wraps 1,2,3,0,1 and done never fires; then stop.
    step(0, 1, 0, 0, 0);
    idle_cycles(5 * 2 * N + 2);
    step(0, 0, 1, 0, 0);
    idle_cycles(2);

    // Start in the same cycle as done is honoured on the next edge.
    step(0, 1, 0, 0, 1);
    idle_cycles(2 * N - 1);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    idle_cycles(2 * N + 2);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 4) == 0),
           int'($urandom_range(0, 3)));
    end
    idle_cycles(2);

    @(negedge Clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("done_activity", 32'(done_seen > 3), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
